// File: rtl/ad2s1210_pkg.sv
//------------------------------------------------------------------------------
// Module   : ad2s1210_pkg
// Purpose  : Shared reader FSM states, dummy byte and AD2S1210 register map.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ad2s1210_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    SEND_ADDR      = 3'd1,
    WAIT_ADDR_RESP = 3'd2,
    SEND_DUMMY     = 3'd3,
    WAIT_DATA_RESP = 3'd4,
    FINISH         = 3'd5
  } reader_state_t;

  localparam logic [7:0] DUMMY_BYTE = 8'h00;

  // AD2S1210 configuration-mode register addresses
  localparam logic [7:0] REG_POSITION_MSB    = 8'h80;
  localparam logic [7:0] REG_POSITION_LSB    = 8'h81;
  localparam logic [7:0] REG_VELOCITY_MSB    = 8'h82;
  localparam logic [7:0] REG_VELOCITY_LSB    = 8'h83;
  localparam logic [7:0] REG_LOS_THRESHOLD   = 8'h88;
  localparam logic [7:0] REG_DOS_OVERRANGE   = 8'h89;
  localparam logic [7:0] REG_DOS_MISMATCH    = 8'h8A;
  localparam logic [7:0] REG_DOS_RESET_MAX   = 8'h8B;
  localparam logic [7:0] REG_DOS_RESET_MIN   = 8'h8C;
  localparam logic [7:0] REG_LOT_HIGH        = 8'h8D;
  localparam logic [7:0] REG_LOT_LOW         = 8'h8E;
  localparam logic [7:0] REG_EXCITATION_FREQ = 8'h91;
  localparam logic [7:0] REG_CONTROL         = 8'hF2;
  localparam logic [7:0] REG_SOFT_RESET      = 8'hF0;
  localparam logic [7:0] REG_FAULT           = 8'hFF;

  function automatic logic is_wait_state(input reader_state_t state);
    return (state == WAIT_ADDR_RESP) || (state == WAIT_DATA_RESP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_stream.sv
//------------------------------------------------------------------------------
// Module   : axi_stream
// Purpose  : Minimal valid/ready byte stream with master and slave views.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface axi_stream #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

`default_nettype wire

// File: rtl/ad2s1210_response_timer.sv
//------------------------------------------------------------------------------
// Module   : ad2s1210_response_timer
// Purpose  : Reloadable watchdog; expired flags the last enabled cycle of the window.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ad2s1210_response_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expired
);

  localparam int              C_COUNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [C_COUNT_WIDTH-1:0] c_last_count = C_COUNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [C_COUNT_WIDTH-1:0] r_count;

  // Counter holds at the terminal value so expired stays asserted until restarted.
  assign expired = enable && (r_count == c_last_count);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (restart) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ad2s1210_register_reader.sv
//------------------------------------------------------------------------------
// Module   : ad2s1210_register_reader
// Purpose  : Reads a table of AD2S1210 registers over an SPI byte stream.
//            Optional READBACK_VERIFY_EN adds expected-value mismatch reporting.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ad2s1210_register_reader
  import ad2s1210_pkg::*;
#(
  parameter int FIRST_INDEX    = 4,
  parameter int LAST_INDEX     = 12,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       read_address [0:14],
  axi_stream.master        spi_transfer,
  axi_stream.slave         spi_response,
  output logic [7:0]       readback_data [0:14],
  output logic             busy,
  output logic             done,
  output logic             timeout
`ifdef READBACK_VERIFY_EN
  ,
  input  logic [7:0]       expected_data [0:14],
  output logic [14:0]      mismatch_mask,
  output logic             mismatch
`endif
);

  localparam logic [3:0] c_first_index = 4'(FIRST_INDEX);
  localparam logic [3:0] c_last_index  = 4'(LAST_INDEX);

  reader_state_t r_state;
  reader_state_t w_next_state;
  logic [3:0]    r_index;
  logic [3:0]    w_next_index;
  logic          r_timeout;
  logic          w_timeout_set;
  logic          w_store;
  logic          w_restart;
  logic          w_wait;
  logic          w_expired;
  logic          w_valid;
  logic [7:0]    w_data;
  logic          w_ready;

  assign w_wait = is_wait_state(r_state);

  ad2s1210_response_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_response_timer (
    .clock  (clock),
    .reset  (reset),
    .restart(w_restart),
    .enable (w_wait),
    .expired(w_expired)
  );

  always_comb begin
    w_next_state  = r_state;
    w_next_index  = r_index;
    w_timeout_set = 1'b0;
    w_store       = 1'b0;
    w_restart     = 1'b0;
    w_valid       = 1'b0;
    w_data        = '0;
    w_ready       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state = SEND_ADDR;
          w_next_index = c_first_index;
        end
      end
      SEND_ADDR: begin
        w_valid = 1'b1;
        w_data  = read_address[r_index];
        if (spi_transfer.ready) begin
          w_next_state = WAIT_ADDR_RESP;
          w_restart    = 1'b1;
        end
      end
      WAIT_ADDR_RESP: begin
        w_ready = 1'b1;
        // A response in the expiry cycle still counts.
        if (spi_response.valid) begin
          w_next_state = SEND_DUMMY;
        end else if (w_expired) begin
          w_next_state  = IDLE;
          w_timeout_set = 1'b1;
        end
      end
      SEND_DUMMY: begin
        w_valid = 1'b1;
        w_data  = DUMMY_BYTE;
        if (spi_transfer.ready) begin
          w_next_state = WAIT_DATA_RESP;
          w_restart    = 1'b1;
        end
      end
      WAIT_DATA_RESP: begin
        w_ready = 1'b1;
        if (spi_response.valid) begin
          w_store = 1'b1;
          if (r_index < c_last_index) begin
            w_next_state = SEND_ADDR;
            w_next_index = r_index + 4'd1;
          end else begin
            w_next_state = FINISH;
          end
        end else if (w_expired) begin
          w_next_state  = IDLE;
          w_timeout_set = 1'b1;
        end
      end
      FINISH: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_index   <= c_first_index;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_index   <= w_next_index;
      r_timeout <= w_timeout_set;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 15; i++) begin
        readback_data[i] <= '0;
      end
    end else if (w_store) begin
      readback_data[r_index] <= spi_response.data;
    end
  end

  assign spi_transfer.valid = w_valid;
  assign spi_transfer.data  = w_data;
  assign spi_response.ready = w_ready;

  assign busy    = (r_state != IDLE) && (r_state != FINISH);
  assign done    = (r_state == FINISH);
  assign timeout = r_timeout;

`ifdef READBACK_VERIFY_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mismatch_mask <= '0;
    end else if ((r_state == IDLE) && start) begin
      mismatch_mask <= '0;
    end else if (w_store && (spi_response.data != expected_data[r_index])) begin
      mismatch_mask[r_index] <= 1'b1;
    end
  end

  assign mismatch = done && (|mismatch_mask);
`endif

endmodule

`default_nettype wire

// File: tb/tb_ad2s1210_register_reader.sv
//------------------------------------------------------------------------------
// Module   : tb_ad2s1210_register_reader
// Purpose  : Directed bench with an echoing SPI slave and transfer scoreboard.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ad2s1210_register_reader;

  localparam int FIRST = 4;
  localparam int LAST  = 12;
  localparam int TMO   = 1024;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] read_address  [0:14];
  logic [7:0] readback_data [0:14];
  logic       busy;
  logic       done;
  logic       timeout;
`ifdef READBACK_VERIFY_EN
  logic [7:0]  expected_data [0:14];
  logic [14:0] mismatch_mask;
  logic        mismatch;
`endif

  axi_stream #(.DATA_WIDTH(8)) spi_transfer ();
  axi_stream #(.DATA_WIDTH(8)) spi_response ();

  always #5 clock = ~clock;

  ad2s1210_register_reader #(
    .FIRST_INDEX   (FIRST),
    .LAST_INDEX    (LAST),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .read_address (read_address),
    .spi_transfer (spi_transfer),
    .spi_response (spi_response),
    .readback_data(readback_data),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout)
`ifdef READBACK_VERIFY_EN
    ,
    .expected_data(expected_data),
    .mismatch_mask(mismatch_mask),
    .mismatch     (mismatch)
`endif
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q [$];
  logic [7:0] resp_q [$];
  logic [7:0] model_rb [0:14];
  int         cyc = 0;
  int         xfer_count = 0;
  int         done_count = 0;
  int         timeout_count = 0;
  int         start_cyc = 0;
  int         done_cyc = 0;
  int         timeout_cyc = 0;
  int         xfer_cyc = 0;
  int         resp_limit = 1000;
  logic [7:0] echo_base = 8'hA0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_readback();
    for (int i = 0; i < 15; i++) begin
      check($sformatf("readback[%0d]", i), 32'(readback_data[i]), 32'(model_rb[i]));
    end
  endtask

  // Scoreboard is loaded with the command bytes the run should produce.
  task automatic start_run(input int ntrans);
    xfer_count    = 0;
    done_count    = 0;
    timeout_count = 0;
    exp_q.delete();
    for (int i = FIRST; i <= LAST; i++) begin
      if (exp_q.size() < ntrans) exp_q.push_back(8'(8'h80 + i));
      if (exp_q.size() < ntrans) exp_q.push_back(8'h00);
    end
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
  endtask

  task automatic run_wait(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!done && !timeout && n < limit);
  endtask

  task automatic settle();
    repeat (3) @(negedge clock);
    #2;
  endtask

  // SPI slave model: echoes junk for address beats and echo_base+index for dummy beats.
  initial begin
    logic       x_hs;
    logic       r_hs;
    logic [7:0] junk;
    int         cur_idx;
    cur_idx = 0;
    spi_response.valid = 1'b0;
    spi_response.data  = 8'h00;
    forever begin
      @(negedge clock);
      cyc++;
      x_hs = 1'b0;
      r_hs = 1'b0;
      if (reset) begin
        x_hs = spi_transfer.valid && spi_transfer.ready;
        r_hs = spi_response.valid && spi_response.ready;
        if (start && !busy) start_cyc = cyc;
        if (done) begin done_count++; done_cyc = cyc; end
        if (timeout) begin timeout_count++; timeout_cyc = cyc; end
        if (x_hs) begin
          xfer_count++;
          xfer_cyc = cyc;
          checks++;
          assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL xfer_extra observed=%0h expected=none", spi_transfer.data);
          end
          if (exp_q.size() > 0) check("xfer_data", 32'(spi_transfer.data), 32'(exp_q.pop_front()));
          if (spi_transfer.data != 8'h00) cur_idx = int'(spi_transfer.data) - 8'h80;
          if (xfer_count <= resp_limit) begin
            if (spi_transfer.data != 8'h00) resp_q.push_back(8'h5A);
            else resp_q.push_back(8'(echo_base + cur_idx));
          end
        end
      end
      @(posedge clock);
      #1;
      if (r_hs && resp_q.size() > 0) junk = resp_q.pop_front();
      if (!reset) resp_q.delete();
      spi_response.valid = (resp_q.size() > 0);
      spi_response.data  = (resp_q.size() > 0) ? resp_q[0] : 8'h00;
    end
  end

  initial begin
    for (int i = 0; i < 15; i++) begin
      read_address[i] = 8'(8'h80 + i);
      model_rb[i]     = 8'h00;
`ifdef READBACK_VERIFY_EN
      expected_data[i] = 8'(8'hA0 + i);
`endif
    end
    spi_transfer.ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_valid", 32'(spi_transfer.valid), 0);
    check("rst_ready", 32'(spi_response.ready), 0);
    check_readback();
    reset = 1'b1;

    // Full table with an always-ready slave
    start_run(18);
    run_wait(200);
    check("t1_done", 32'(done), 1);
`ifdef READBACK_VERIFY_EN
    check("t1_mismatch", 32'(mismatch), 0);
`endif
    settle();
    for (int i = FIRST; i <= LAST; i++) model_rb[i] = 8'(8'hA0 + i);
    check("t1_done_count", 32'(done_count), 1);
    check("t1_xfers", 32'(xfer_count), 18);
    check("t1_sb_empty", 32'(exp_q.size()), 0);
    check("t1_latency", 32'(done_cyc - start_cyc), 37);
    check("t1_busy", 32'(busy), 0);
    check_readback();

    // Transfer stalled for 5 cycles on the first address beat
    spi_transfer.ready = 1'b0;
    start_run(18);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("t2_hold_valid", 32'(spi_transfer.valid), 1);
      check("t2_hold_data", 32'(spi_transfer.data), 32'h84);
      check("t2_hold_busy", 32'(busy), 1);
    end
    @(posedge clock); #1 spi_transfer.ready = 1'b1;
    run_wait(200);
    check("t2_done", 32'(done), 1);
    settle();
    check("t2_done_count", 32'(done_count), 1);
    check("t2_xfers", 32'(xfer_count), 18);
    check_readback();

    // No response to the third address: watchdog abort
    echo_base  = 8'hB0;
    resp_limit = 4;
    start_run(5);
    run_wait(TMO + 200);
    check("t3_timeout", 32'(timeout), 1);
    check("t3_busy", 32'(busy), 0);
    settle();
    model_rb[4] = 8'hB4;
    model_rb[5] = 8'hB5;
    // Handshake is observed on the negedge before its edge, timeout on the one after.
    check("t3_timeout_cycles", 32'(timeout_cyc - xfer_cyc), 32'(TMO + 1));
    check("t3_timeout_count", 32'(timeout_count), 1);
    check("t3_done_count", 32'(done_count), 0);
    check("t3_xfers", 32'(xfer_count), 5);
    check("t3_sb_empty", 32'(exp_q.size()), 0);
    check_readback();
    echo_base  = 8'hA0;
    resp_limit = 1000;

    // Reset while waiting for the data byte
    resp_limit = 1;
    start_run(2);
    for (int k = 0; k < 50 && xfer_count < 2; k++) @(negedge clock);
    repeat (3) @(negedge clock);
    check("t4_busy_before", 32'(busy), 1);
    check("t4_ready_before", 32'(spi_response.ready), 1);
    #2 reset = 1'b0;
    #1;
    check("t4_busy", 32'(busy), 0);
    check("t4_done", 32'(done), 0);
    check("t4_timeout", 32'(timeout), 0);
    check("t4_valid", 32'(spi_transfer.valid), 0);
    check("t4_data", 32'(spi_transfer.data), 0);
    check("t4_ready", 32'(spi_response.ready), 0);
    check("t4_sb_empty", 32'(exp_q.size()), 0);
    for (int i = 0; i < 15; i++) model_rb[i] = 8'h00;
    check_readback();
    resp_q.delete();
    resp_limit = 1000;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    start_run(18);
    run_wait(200);
    check("t4_done_after", 32'(done), 1);
    settle();
    for (int i = FIRST; i <= LAST; i++) model_rb[i] = 8'(8'hA0 + i);
    check("t4_xfers", 32'(xfer_count), 18);
    check_readback();

    // Start pulsed again mid-sequence is ignored
    start_run(18);
    repeat (10) @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    run_wait(200);
    check("t5_done", 32'(done), 1);
    repeat (10) @(negedge clock);
    #2;
    check("t5_done_count", 32'(done_count), 1);
    check("t5_xfers", 32'(xfer_count), 18);
    check("t5_busy", 32'(busy), 0);
    check_readback();

`ifdef READBACK_VERIFY_EN
    // Expected value for entry 7 deliberately wrong
    expected_data[7] = 8'h00;
    start_run(18);
    run_wait(200);
    check("t6_done", 32'(done), 1);
    check("t6_mismatch", 32'(mismatch), 1);
    check("t6_mask", 32'(mismatch_mask), 32'h0080);
    settle();
    expected_data[7] = 8'hA7;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
